// File: rtl/hand_step_input.sv
// Operator step-button and display-switch front end: synchronises and debounces the raw inputs,
// producing the single-step clock level, a per-press strobe, the stable switch value and a count.
module hand_step_input #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned STEP_HIGH_CYCLES = 50000,
  parameter int unsigned CNT_W            = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic [1:0] sw_raw,
  output logic       clk_step,
  output logic       step_pulse,
  output logic       key_level,
  output logic [1:0] sw_stable,
  output logic [7:0] press_count
);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StPressed     = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  localparam logic [CNT_W-1:0] CntZero  = '0;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HighLoad = CNT_W'(STEP_HIGH_CYCLES - 1);

  // Two-flop synchronisers for the asynchronous board inputs.
  logic       key_meta_q, key_s_q;
  logic [1:0] sw_meta_q, sw_s_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             clk_step_q, clk_step_d;
  logic [7:0]       press_count_q, press_count_d;

  logic [1:0]       sw_prev_q, sw_prev_d;
  logic [1:0]       sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0] swcnt_q, swcnt_d;

  // Key debounce FSM; the strobe is produced only on the PRESS_WAIT -> PRESSED transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_s_q) begin
          state_d = StPressWait;
          cnt_d   = CntOne;
        end
      end
      StPressWait: begin
        if (!key_s_q) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d = StPressed;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPressed: begin
        if (!key_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = CntOne;
        end
      end
      StReleaseWait: begin
        if (key_s_q) begin
          state_d = StPressed;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    level_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

  // Step clock high phase; a new strobe reloads the counter even if already high.
  always_comb begin
    clk_step_d = clk_step_q;
    hcnt_d     = hcnt_q;
    if (pulse_d) begin
      clk_step_d = 1'b1;
      hcnt_d     = HighLoad;
    end else if (clk_step_q) begin
      if (hcnt_q == CntZero) begin
        clk_step_d = 1'b0;
      end else begin
        hcnt_d = hcnt_q - CntOne;
      end
    end
  end

  always_comb begin
    press_count_d = press_count_q;
    if (pulse_q) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  // Switch debounce: both bits form one vector, so any bit change restarts the count.
  always_comb begin
    sw_prev_d   = sw_s_q;
    sw_stable_d = sw_stable_q;
    swcnt_d     = swcnt_q;
    if ((sw_s_q != sw_prev_q) || (sw_s_q == sw_stable_q)) begin
      swcnt_d = CntOne;
    end else if (swcnt_q == DebLast) begin
      sw_stable_d = sw_s_q;
    end else begin
      swcnt_d = swcnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_meta_q    <= 1'b0;
      key_s_q       <= 1'b0;
      sw_meta_q     <= 2'b00;
      sw_s_q        <= 2'b00;
      state_q       <= StIdle;
      cnt_q         <= CntZero;
      pulse_q       <= 1'b0;
      level_q       <= 1'b0;
      hcnt_q        <= CntZero;
      clk_step_q    <= 1'b0;
      press_count_q <= 8'd0;
      sw_prev_q     <= 2'b00;
      sw_stable_q   <= 2'b00;
      swcnt_q       <= CntZero;
    end else begin
      key_meta_q    <= key_raw;
      key_s_q       <= key_meta_q;
      sw_meta_q     <= sw_raw;
      sw_s_q        <= sw_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pulse_q       <= pulse_d;
      level_q       <= level_d;
      hcnt_q        <= hcnt_d;
      clk_step_q    <= clk_step_d;
      press_count_q <= press_count_d;
      sw_prev_q     <= sw_prev_d;
      sw_stable_q   <= sw_stable_d;
      swcnt_q       <= swcnt_d;
    end
  end

  assign clk_step    = clk_step_q;
  assign step_pulse  = pulse_q;
  assign key_level   = level_q;
  assign sw_stable   = sw_stable_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_hand_step_input.sv
// Bench for hand_step_input with DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3, checked against a
// window-based reference model plus directed latency expectations.
module tb_hand_step_input;

  localparam int D = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_raw = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic       clk_step, step_pulse, key_level;
  logic [1:0] sw_stable;
  logic [7:0] press_count;

  int tests = 0;
  int fails = 0;

  hand_step_input #(
    .DEBOUNCE_CYCLES (D),
    .STEP_HIGH_CYCLES(H),
    .CNT_W           (21)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .sw_raw     (sw_raw),
    .clk_step   (clk_step),
    .step_pulse (step_pulse),
    .key_level  (key_level),
    .sw_stable  (sw_stable),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last D synchronised samples all disagree with it.
  logic       m_k1, m_k2;
  logic [1:0] m_s1, m_s2;
  logic       key_win[$];
  logic [1:0] sw_win[$];
  logic       m_level, m_pulse;
  int         m_high_left;
  logic [7:0] m_count;
  logic [1:0] m_sw_stable;

  function automatic void model_edge(input logic k, input logic [1:0] s, input logic r);
    logic       ks;
    logic [1:0] ss;
    logic       flip, sw_ok;
    if (!r) begin
      m_k1 = 0; m_k2 = 0; m_s1 = 0; m_s2 = 0;
      key_win.delete(); sw_win.delete();
      m_level = 0; m_pulse = 0; m_high_left = 0; m_count = 0; m_sw_stable = 0;
      return;
    end
    ks = m_k2; ss = m_s2;
    m_k2 = m_k1; m_k1 = k;
    m_s2 = m_s1; m_s1 = s;
    key_win.push_back(ks);
    if (key_win.size() > D) void'(key_win.pop_front());
    flip = (key_win.size() == D);
    foreach (key_win[i]) if (key_win[i] == m_level) flip = 0;
    if (m_pulse) m_count = m_count + 8'd1;
    m_pulse = flip && !m_level;
    if (flip) m_level = !m_level;
    if (m_pulse) m_high_left = H;
    else if (m_high_left > 0) m_high_left--;
    sw_win.push_back(ss);
    if (sw_win.size() > D) void'(sw_win.pop_front());
    sw_ok = (sw_win.size() == D) && (ss != m_sw_stable);
    foreach (sw_win[i]) if (sw_win[i] != ss) sw_ok = 0;
    if (sw_ok) m_sw_stable = ss;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_high_left > 0, m_pulse, m_level, m_sw_stable, m_count};
  endfunction

  logic [12:0] dut_vec;
  assign dut_vec = {clk_step, step_pulse, key_level, sw_stable, press_count};

  task automatic tick(input logic k, input logic [1:0] s, input logic r);
    key_raw = k; sw_raw = s; reset = r;
    @(posedge clk);
    model_edge(k, s, r);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    tick(1'b1, 2'b11, 1'b0);
    tick(1'b1, 2'b11, 1'b0);
    tests++;
    if (dut_vec !== 13'd0) begin
      fails++; $display("FAIL reset_state: got %h expected 0000", dut_vec);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    do_reset();
    for (int e = 0; e < 10; e++) begin
      tick(1'b1, 2'b00, 1'b1);
      exp = {(e >= 5 && e <= 7), (e == 5), (e >= 5), (e >= 6)};
      tests++;
      if ({clk_step, step_pulse, key_level, press_count == 8'd1} !== exp) begin
        fails++;
        $display("FAIL clean_press edge %0d: got cs/sp/kl/cnt1=%b expected %b", e,
                 {clk_step, step_pulse, key_level, press_count == 8'd1}, exp);
      end
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL clean_press_model e%0d: got %h expected %h", e, dut_vec, exp_vec());
      end
    end
    for (int f = 0; f < 8; f++) begin
      tick(1'b0, 2'b00, 1'b1);
      tests++;
      if (key_level !== (f < 5)) begin
        fails++; $display("FAIL release_level f%0d: got %b expected %b", f, key_level, f < 5);
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic pat[13] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    foreach (pat[i]) begin
      tick(pat[i], 2'b00, 1'b1);
      tests++;
      if ({clk_step, step_pulse, key_level} !== 3'b000 || dut_vec !== exp_vec()) begin
        fails++; $display("FAIL bounce_reject c%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    tests++;
    if (press_count !== 8'd0) begin
      fails++; $display("FAIL bounce_count: got %0d expected 0", press_count);
    end
  endtask

  task automatic test_release_bounce();
    logic pat[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 2'b00, 1'b1);
    foreach (pat[i]) begin
      tick(pat[i], 2'b00, 1'b1);
      tests++;
      if (step_pulse !== 1'b0 || key_level !== 1'b1 || press_count !== 8'd1) begin
        fails++;
        $display("FAIL release_bounce c%0d: got sp=%b kl=%b cnt=%0d expected sp=0 kl=1 cnt=1",
                 i, step_pulse, key_level, press_count);
      end
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL release_bounce_model c%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 2'b00, 1'b1);
    tick(1'b1, 2'b00, 1'b0);
    tests++;
    if (dut_vec !== 13'd0) begin
      fails++; $display("FAIL reset_mid_debounce: got %h expected 0000", dut_vec);
    end
    // First post-reset edge re-samples the key, so the strobe follows its sixth edge.
    for (int j = 0; j < 9; j++) begin
      tick(1'b1, 2'b00, 1'b1);
      tests++;
      if (step_pulse !== (j == 5) || dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL reset_mid_repress j%0d: got sp=%b vec=%h expected sp=%b vec=%h", j,
                 step_pulse, dut_vec, j == 5, exp_vec());
      end
    end
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 2'b00, 1'b1);
    tick(1'b0, 2'b00, 1'b0);
    tests++;
    if (clk_step !== 1'b0 || dut_vec !== 13'd0) begin
      fails++; $display("FAIL reset_high_phase: got cs=%b vec=%h expected 0", clk_step, dut_vec);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 2'b00, 1'b1);
      tests++;
      if (step_pulse !== 1'b0 || clk_step !== 1'b0) begin
        fails++; $display("FAIL reset_high_after c%0d: got sp=%b cs=%b expected 0", i, step_pulse,
                          clk_step);
      end
    end
  endtask

  task automatic test_switches();
    logic [1:0] s;
    do_reset();
    for (int e = 0; e < 8; e++) begin
      tick(1'b0, 2'b10, 1'b1);
      tests++;
      if (sw_stable !== ((e >= 5) ? 2'b10 : 2'b00) || dut_vec !== exp_vec()) begin
        fails++; $display("FAIL sw_accept e%0d: got %b expected %b", e, sw_stable,
                          (e >= 5) ? 2'b10 : 2'b00);
      end
    end
    for (int i = 0; i < 20; i++) begin
      s = ((i / 2) % 2 == 0) ? 2'b11 : 2'b10;
      tick(1'b0, s, 1'b1);
      tests++;
      if (sw_stable !== 2'b10 || dut_vec !== exp_vec()) begin
        fails++; $display("FAIL sw_toggle c%0d: got %b expected 10", i, sw_stable);
      end
    end
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      pulses = 0;
      for (int c = 0; c < 16; c++) begin
        tick(c < 8, 2'b01, 1'b1);
        if (step_pulse === 1'b1) pulses++;
        if (dut_vec !== exp_vec()) begin
          fails++; $display("FAIL wrap_model p%0d c%0d: got %h expected %h", p, c, dut_vec,
                            exp_vec());
        end
      end
      tests++;
      if (pulses != 1 || press_count !== 8'((p + 1) % 256)) begin
        fails++; $display("FAIL wrap_press p%0d: got pulses=%0d cnt=%0d expected 1 and %0d", p,
                          pulses, press_count, (p + 1) % 256);
      end
    end
  endtask

  task automatic test_random();
    int         krun = 0;
    int         srun = 0;
    logic       k = 1'b0;
    logic [1:0] s = 2'b00;
    logic       r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (krun == 0) begin k = 1'($urandom_range(0, 1)); krun = $urandom_range(1, 7); end
      if (srun == 0) begin s = 2'($urandom_range(0, 3)); srun = $urandom_range(1, 6); end
      krun--; srun--;
      r = ($urandom_range(0, 199) != 0);
      tick(k, s, r);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random c%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_edge(1'b0, 2'b00, 1'b0);
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_bounce();
    test_reset_mid();
    test_switches();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
